dif_tf_pow_gen: RTL and testbench
=================================

# dif_tf_pow_gen

Twiddle-power generator for the radix-16 DIF NTT datapath. It sits directly downstream of the constant twiddle ROM: it latches one 64-bit base twiddle w (e.g. tf1/tf5/tf9/tf13) and streams the powers w^0 … w^15 mod p to the butterfly multipliers over a valid/ready handshake. Arithmetic is over the Goldilocks prime p = 2^64 − 2^32 + 1 = 64'hFFFFFFFF00000001.

## Interface
- P_WIDTH, 64, twiddle word width; fixed by the modulus, only 64 is supported.
- CNT_WIDTH, 4, power-index width; one burst is 2^CNT_WIDTH = 16 powers.
- SC_WIDTH, 3, stage-counter width.

- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a burst; sampled only when ready=1.
- base_in  input  P_WIDTH  base twiddle w; sampled with start.
- stage_in  input  SC_WIDTH  stage tag; sampled with start.
- ready  output  1  high in IDLE; combinational from state.
- tf_valid  output  1  tf_out holds a valid power.
- tf_ready  input  1  downstream accepts the beat when tf_valid && tf_ready.
- tf_out  output  P_WIDTH  current power w^tf_idx mod p, canonical (< p).
- tf_idx  output  CNT_WIDTH  exponent of tf_out.
- tf_last  output  1  high with the beat where tf_idx = 15.
- tf_stage  output  SC_WIDTH  stage tag latched at start.

## Operation
- States: IDLE and RUN.
- IDLE, start=1 (and gate passes, see Configuration):
  - latch base_reg = canonical(base_in); canonical(x) = x − p if x ≥ p, else x.
  - set tf_out=1, tf_idx=0, tf_valid=1, tf_stage=stage_in; go to RUN.
- RUN, beat accepted:
  - tf_out ← modmul(tf_out, base_reg); tf_idx ← tf_idx+1.
  - On the tf_last beat: tf_valid←0, tf_last←0, go to IDLE.
- RUN, tf_valid=1 and tf_ready=0: tf_out, tf_idx and tf_last hold stable.
- start during RUN is ignored. No back-to-back: ready is low on the final beat's cycle.
- modmul: full 128-bit product, then Goldilocks reduction. With product = {a(32),b(32),c(64)}: r = c − a + b·(2^32−1) mod p, with conditional ±p corrections. Result is always < p.
  - Combinational in the same cycle; registered into tf_out.
- tf_last = (tf_idx == 15) && tf_valid, registered with tf_idx.
- Reset (async, any state): state=IDLE, tf_valid=0, tf_out=0, tf_idx=0, tf_last=0, tf_stage=0, base_reg=0.
  - A burst interrupted by reset is abandoned; no partial resumption.

## Timing
- start sampled at edge T → tf_valid=1, tf_out=1, tf_idx=0 after edge T.
- With tf_ready held high, a burst is 16 beats occupying cycles T+1..T+16.
  - tf_last is high in cycle T+16; ready=1 from cycle T+17.
- Each stall cycle (tf_ready=0) extends the burst by exactly one cycle.
- Throughput: one power per cycle, since each product feeds the next multiply in a single cycle.

## Configuration
- DIF_TF_STAGE_GATE_EN defined: start is accepted only when stage_in == 0, matching the ROM's stage-0 load. Otherwise start is ignored and ready stays 1.
- DIF_TF_STAGE_GATE_EN undefined: start is accepted for any stage_in value.

## Test plan
- base_in=2, stage_in=0, tf_ready=1 → tf_out = 1,2,4,…,32768 at idx 0..15; tf_last only at idx 15; ready high again 17 cycles after start.
- base_in=64'hFFFFFFFF00000000 (p−1) → tf_out alternates 1, p−1; idx 15 carries p−1.
- base_in=p+5 (64'hFFFFFFFF00000006) → canonicalised to 5; tf_out = 1,5,25,125,…, each value < p.
- base_in=64'h381d997f2d35d682, tf_ready toggled 1,0,0,1,…:
  - outputs hold during stalls; the sequence matches a golden modexp model; burst length = 16 + stall count.
- start pulsed mid-burst → ignored, sequence unaffected.
  - rst_n low at idx 7 → all outputs 0 and ready=1 immediately; the next start restarts at tf_out=1.
- stage_in=3 with start:
  - with DIF_TF_STAGE_GATE_EN: no burst, tf_valid stays 0.
  - without it: burst runs and tf_stage=3.

Source files
------------

// File: rtl/dif_tf_pow_gen.sv
// dif_tf_pow_gen: streams w^0..w^15 mod p (Goldilocks p = 2^64-2^32+1) for one latched base twiddle.
// Ports:
//   clk, rst_n (async, active-low)
//   start, base_in, stage_in : burst request, sampled only while ready=1
//   ready                    : high in IDLE
//   tf_valid, tf_ready       : output handshake; a beat moves when both are high
//   tf_out, tf_idx           : current power and its exponent
//   tf_last                  : marks the beat with tf_idx = 15
//   tf_stage                 : stage tag latched with start
// Optional build macro DIF_TF_STAGE_GATE_EN: accept start only when stage_in == 0.
module dif_tf_pow_gen #(
    parameter int P_WIDTH   = 64,
    parameter int CNT_WIDTH = 4,
    parameter int SC_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [P_WIDTH-1:0]   base_in,
    input  logic [SC_WIDTH-1:0]  stage_in,
    output logic                 ready,
    output logic                 tf_valid,
    input  logic                 tf_ready,
    output logic [P_WIDTH-1:0]   tf_out,
    output logic [CNT_WIDTH-1:0] tf_idx,
    output logic                 tf_last,
    output logic [SC_WIDTH-1:0]  tf_stage
);
    localparam logic [63:0] P  = 64'hFFFFFFFF00000001;
    localparam logic [66:0] PW = {3'b000, P};

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [P_WIDTH-1:0]   base_reg, base_n, out_n, prod_r;
    logic [CNT_WIDTH-1:0] idx_n;
    logic [SC_WIDTH-1:0]  stage_n;
    logic                 valid_n, last_n, accept;
    logic [127:0]         prod;
    logic [63:0]          mid;
    logic [66:0]          s0, s1, s2, s3;

`ifdef DIF_TF_STAGE_GATE_EN
    assign accept = start && (stage_in == '0);
`else
    assign accept = start;
`endif

    assign ready = (state == IDLE);

    // Goldilocks reduction: 2^64 = 2^32-1 and 2^96 = -1 (mod p), so
    // {a,b,c} reduces to c - a + b*(2^32-1). The 67-bit sum lies in (-2^32, 2^65),
    // so one +p fix for a negative result and at most two -p steps make it canonical.
    always_comb begin
        prod   = {64'b0, tf_out} * {64'b0, base_reg};
        mid    = {prod[95:64], 32'b0} - {32'b0, prod[95:64]};
        s0     = {3'b000, prod[63:0]} + {3'b000, mid} - {35'b0, prod[127:96]};
        s1     = s0[66] ? s0 + PW : s0;
        s2     = (s1 >= PW) ? s1 - PW : s1;
        s3     = (s2 >= PW) ? s2 - PW : s2;
        prod_r = s3[63:0];
    end

    always_comb begin
        state_n = state;
        base_n  = base_reg;
        out_n   = tf_out;
        idx_n   = tf_idx;
        valid_n = tf_valid;
        last_n  = tf_last;
        stage_n = tf_stage;
        if (state == IDLE) begin
            if (accept) begin
                state_n = RUN;
                base_n  = (base_in >= P) ? base_in - P : base_in;
                out_n   = P_WIDTH'(1);
                idx_n   = '0;
                valid_n = 1'b1;
                last_n  = 1'b0;
                stage_n = stage_in;
            end
        end else if (tf_ready) begin
            out_n  = prod_r;
            idx_n  = tf_idx + 1'b1;
            last_n = &idx_n;
            if (tf_last) begin
                state_n = IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_reg <= '0;
            tf_out   <= '0;
            tf_idx   <= '0;
            tf_valid <= 1'b0;
            tf_last  <= 1'b0;
            tf_stage <= '0;
        end else begin
            state    <= state_n;
            base_reg <= base_n;
            tf_out   <= out_n;
            tf_idx   <= idx_n;
            tf_valid <= valid_n;
            tf_last  <= last_n;
            tf_stage <= stage_n;
        end
    end
endmodule

// File: tb/tb_dif_tf_pow_gen.sv
// tb_dif_tf_pow_gen: table-driven check of the twiddle-power burst generator against a modulo-operator model.
module tb_dif_tf_pow_gen;
    localparam logic [63:0] P = 64'hFFFFFFFF00000001;

    logic        clk, rst_n, start, ready, tf_valid, tf_ready, tf_last;
    logic [63:0] base_in, tf_out;
    logic [2:0]  stage_in, tf_stage;
    logic [3:0]  tf_idx;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [63:0] base;
        logic [2:0]  stage;
        logic [3:0]  pat;
        logic        glitch;
        logic [63:0] w1;
        logic        has15;
        logic [63:0] w15;
        int          len;
    } vec_t;

    vec_t vecs[5];

    dif_tf_pow_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_in(base_in), .stage_in(stage_in),
        .ready(ready), .tf_valid(tf_valid), .tf_ready(tf_ready), .tf_out(tf_out),
        .tf_idx(tf_idx), .tf_last(tf_last), .tf_stage(tf_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x;
        x = ({64'b0, a} * {64'b0, b}) % {64'b0, P};
        return x[63:0];
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Entered and left on a negedge; tf_ready follows v.pat[cycle % 4].
    task automatic run_burst(input vec_t v);
        int          beat, cyc;
        logic [63:0] w, pw;
        logic        rd;
        w = (v.base >= P) ? v.base - P : v.base;
        pw = 64'd1;
        beat = 0;
        cyc = 0;
        chk("ready_before", {63'b0, ready}, 64'd1);
        start = 1'b1;
        base_in = v.base;
        stage_in = v.stage;
        @(negedge clk);
        start = 1'b0;
        while (beat < 16 && cyc < 64) begin
            chk("valid", {63'b0, tf_valid}, 64'd1);
            chk("idx", {60'b0, tf_idx}, 64'(beat));
            chk("out", tf_out, pw);
            chk("canon", {63'b0, tf_out < P}, 64'd1);
            chk("last", {63'b0, tf_last}, {63'b0, beat == 15});
            chk("ready_busy", {63'b0, ready}, 64'd0);
            chk("stage", {61'b0, tf_stage}, {61'b0, v.stage});
            if (beat == 1) chk("out_w1", tf_out, v.w1);
            if (beat == 15 && v.has15) chk("out_w15", tf_out, v.w15);
            rd = v.pat[cyc % 4];
            tf_ready = rd;
            start = v.glitch && cyc == 5;
            base_in = start ? 64'd9 : v.base;
            stage_in = start ? 3'd5 : v.stage;
            @(negedge clk);
            cyc++;
            if (rd) begin
                beat++;
                pw = mm(pw, w);
            end
        end
        start = 1'b0;
        tf_ready = 1'b1;
        chk("burst_len", 64'(cyc), 64'(v.len));
        chk("valid_end", {63'b0, tf_valid}, 64'd0);
        chk("ready_end", {63'b0, ready}, 64'd1);
    endtask

    initial begin
        logic [2:0] rs_stage;
`ifdef DIF_TF_STAGE_GATE_EN
        rs_stage = 3'd0;
`else
        rs_stage = 3'd2;
`endif
        vecs[0] = '{64'd2, 3'd0, 4'hF, 1'b0, 64'd2, 1'b1, 64'd32768, 16};
        vecs[1] = '{P - 64'd1, 3'd0, 4'hF, 1'b0, P - 64'd1, 1'b1, P - 64'd1, 16};
        vecs[2] = '{64'hFFFFFFFF00000006, 3'd0, 4'hF, 1'b0, 64'd5, 1'b1, 64'd30517578125, 16};
        vecs[3] = '{64'h381d997f2d35d682, 3'd0, 4'b1001, 1'b0, 64'h381d997f2d35d682, 1'b0, 64'd0, 32};
        vecs[4] = '{64'd3, 3'd0, 4'hF, 1'b1, 64'd3, 1'b1, 64'd14348907, 16};

        rst_n = 1'b0;
        start = 1'b0;
        base_in = '0;
        stage_in = '0;
        tf_ready = 1'b1;
        #12;
        chk("rst_valid", {63'b0, tf_valid}, 64'd0);
        chk("rst_out", tf_out, 64'd0);
        chk("rst_idx", {60'b0, tf_idx}, 64'd0);
        chk("rst_last", {63'b0, tf_last}, 64'd0);
        chk("rst_stage", {61'b0, tf_stage}, 64'd0);
        chk("rst_ready", {63'b0, ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Reset in the middle of a burst, then a clean restart.
        start = 1'b1;
        base_in = 64'd2;
        stage_in = rs_stage;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_idx", {60'b0, tf_idx}, 64'd7);
        chk("mid_out", tf_out, 64'd128);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'b0, tf_valid}, 64'd0);
        chk("arst_out", tf_out, 64'd0);
        chk("arst_idx", {60'b0, tf_idx}, 64'd0);
        chk("arst_stage", {61'b0, tf_stage}, 64'd0);
        chk("arst_ready", {63'b0, ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(vecs[0]);

        // Nonzero stage tag with start.
`ifdef DIF_TF_STAGE_GATE_EN
        start = 1'b1;
        base_in = 64'd2;
        stage_in = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("gate_valid", {63'b0, tf_valid}, 64'd0);
            chk("gate_ready", {63'b0, ready}, 64'd1);
            @(negedge clk);
        end
`else
        run_burst('{64'd2, 3'd3, 4'hF, 1'b0, 64'd2, 1'b1, 64'd32768, 16});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
